// File: rtl/alu4_issue_ctrl.sv
// Issue/writeback controller for a combinational 4-bit ALU: owns a 4x4 operand register file,
// issues registered operands, waits EXEC_CYCLES, then captures and presents the result.
module alu4_issue_ctrl #(
  parameter int unsigned EXEC_CYCLES = 1,
  parameter bit          WRITEBACK   = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       in_load,
  input  logic [7:0] in_data,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic [3:0] alu_opcode,
  input  logic [3:0] alu_out,
  input  logic       alu_z,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [3:0] res_data,
  output logic       res_z,
  output logic [7:0] op_count
);

  if (EXEC_CYCLES < 1 || EXEC_CYCLES > 4) begin : g_bad_exec_cycles
    $error("alu4_issue_ctrl: EXEC_CYCLES must be in 1..4");
  end

  localparam logic [1:0] CntInit = 2'(EXEC_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e      state_q, state_d;
  logic [3:0]  rf_q [4];
  logic [3:0]  rf_d [4];
  logic [3:0]  alu_a_q, alu_a_d;
  logic [3:0]  alu_b_q, alu_b_d;
  logic [3:0]  alu_op_q, alu_op_d;
  logic [1:0]  ra_q, ra_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [3:0]  res_data_q, res_data_d;
  logic        res_z_q, res_z_d;
  logic        res_valid_q, res_valid_d;
  logic        in_ready_q, in_ready_d;
  logic [7:0]  op_count_q, op_count_d;

  always_comb begin
    state_d     = state_q;
    rf_d        = rf_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_op_d    = alu_op_q;
    ra_d        = ra_q;
    cnt_d       = cnt_q;
    res_data_d  = res_data_q;
    res_z_d     = res_z_q;
    res_valid_d = res_valid_q;
    in_ready_d  = in_ready_q;
    op_count_d  = op_count_q;

    case (state_q)
      StIdle: begin
        if (in_valid) begin
          if (in_load) begin
            rf_d[in_data[5:4]] = in_data[3:0];
          end else begin
            // Operands come from the pre-edge register file contents.
            alu_a_d    = rf_q[in_data[3:2]];
            alu_b_d    = rf_q[in_data[1:0]];
            alu_op_d   = in_data[7:4];
            ra_d       = in_data[3:2];
            cnt_d      = CntInit;
            in_ready_d = 1'b0;
            state_d    = StExec;
          end
        end
      end
      StExec: begin
        if (cnt_q != 2'd0) begin
          cnt_d = cnt_q - 2'd1;
        end else begin
          res_data_d  = alu_out;
          res_z_d     = alu_z;
          if (WRITEBACK) begin
            rf_d[ra_q] = alu_out;
          end
          op_count_d  = op_count_q + 8'd1;
          res_valid_d = 1'b1;
          state_d     = StResp;
        end
      end
      StResp: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = StIdle;
        end
      end
      default: begin
        res_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        state_d     = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      for (int i = 0; i < 4; i++) begin
        rf_q[i] <= 4'd0;
      end
      alu_a_q     <= 4'd0;
      alu_b_q     <= 4'd0;
      alu_op_q    <= 4'd0;
      ra_q        <= 2'd0;
      cnt_q       <= 2'd0;
      res_data_q  <= 4'd0;
      res_z_q     <= 1'b0;
      res_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      op_count_q  <= 8'd0;
    end else begin
      state_q     <= state_d;
      rf_q        <= rf_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_op_q    <= alu_op_d;
      ra_q        <= ra_d;
      cnt_q       <= cnt_d;
      res_data_q  <= res_data_d;
      res_z_q     <= res_z_d;
      res_valid_q <= res_valid_d;
      in_ready_q  <= in_ready_d;
      op_count_q  <= op_count_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_opcode = alu_op_q;
  assign res_valid  = res_valid_q;
  assign res_data   = res_data_q;
  assign res_z      = res_z_q;
  assign op_count   = op_count_q;

endmodule
